// File: rtl/uart_debug_loader.sv
// UART-driven debug loader: receives A5-framed commands and turns them into memory
// write strobes, memory clear pulses and core reset control. Optional 8E1 format: UART_DEBUG_LOADER_PARITY_EN.
module uart_debug_loader #(
  parameter int CyclesPerBit = 104,
  parameter int AddrWidth    = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 debug_o,
  output logic [AddrWidth-1:0] debug_addr_o,
  output logic [7:0]           debug_data_o,
  output logic                 debug_imem_o,
  output logic                 debug_full_reset_o,
  output logic                 cpu_reset_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int CntWidth = $clog2(CyclesPerBit);
  localparam logic [CntWidth-1:0] BitLast  = CntWidth'(CyclesPerBit - 1);
  localparam logic [CntWidth-1:0] HalfLast = CntWidth'(CyclesPerBit / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_DEBUG_LOADER_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    FR_SYNC, FR_CMD, FR_ADDR_HI, FR_ADDR_LO, FR_LEN_HI, FR_LEN_LO, FR_DATA
  } fr_state_t;

  rx_state_t rx_state, rx_next;
  fr_state_t fr_state, fr_next;

  logic                rx_meta, rx_sync, rx_prev;
  logic [CntWidth-1:0] cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          rx_byte;
  logic                cnt_clr, shift_en, byte_valid, rx_err;

  logic [7:0]           addr_hi;
  logic [15:0]          len;
  logic [AddrWidth-1:0] cur_addr;
  logic                 err_set, err_clr, full_pulse, run, cmd_write, wr;

  // Synchronizer and edge-detect flops idle high, matching the line's idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_next;
      cnt      <= cnt_clr ? '0 : cnt + CntWidth'(1);
      if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
        rx_byte <= {rx_sync, rx_byte[7:1]};
      end
    end
  end

  always_comb begin
    rx_next    = rx_state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    byte_valid = 1'b0;
    rx_err     = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_next = RX_START;
          cnt_clr = 1'b1;
        end
      end
      RX_START: begin
        if (cnt == HalfLast) begin
          cnt_clr = 1'b1;
          rx_next = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BitLast) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_DEBUG_LOADER_PARITY_EN
            rx_next = RX_PARITY;
`else
            rx_next = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_DEBUG_LOADER_PARITY_EN
      RX_PARITY: begin
        if (cnt == BitLast) begin
          cnt_clr = 1'b1;
          if (rx_sync != ^rx_byte) begin
            rx_err  = 1'b1;
            rx_next = RX_IDLE;
          end else begin
            rx_next = RX_STOP;
          end
        end
      end
`endif
      RX_STOP: begin
        if (cnt == BitLast) begin
          cnt_clr = 1'b1;
          rx_next = RX_IDLE;
          if (rx_sync) byte_valid = 1'b1;
          else         rx_err     = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    fr_next    = fr_state;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    full_pulse = 1'b0;
    run        = 1'b0;
    cmd_write  = 1'b0;
    wr         = 1'b0;
    if (byte_valid) begin
      unique case (fr_state)
        FR_SYNC: begin
          if (rx_byte == 8'hA5) begin
            fr_next = FR_CMD;
            err_clr = 1'b1;
          end
        end
        FR_CMD: begin
          fr_next = FR_SYNC;
          unique case (rx_byte)
            8'h01, 8'h02: begin
              fr_next   = FR_ADDR_HI;
              cmd_write = 1'b1;
            end
            8'h03:   full_pulse = 1'b1;
            8'h04:   run        = 1'b1;
            default: err_set    = 1'b1;
          endcase
        end
        FR_ADDR_HI: fr_next = FR_ADDR_LO;
        FR_ADDR_LO: fr_next = FR_LEN_HI;
        FR_LEN_HI:  fr_next = FR_LEN_LO;
        FR_LEN_LO:  fr_next = ({len[15:8], rx_byte} == 16'd0) ? FR_SYNC : FR_DATA;
        FR_DATA: begin
          wr = 1'b1;
          if (len == 16'd1) fr_next = FR_SYNC;
        end
        default: fr_next = FR_SYNC;
      endcase
    end
    // A framing or parity error abandons whatever frame was in progress.
    if (rx_err) begin
      fr_next = FR_SYNC;
      err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fr_state           <= FR_SYNC;
      debug_o            <= 1'b0;
      debug_full_reset_o <= 1'b0;
      debug_addr_o       <= '0;
      debug_data_o       <= '0;
      debug_imem_o       <= 1'b0;
      cpu_reset_o        <= 1'b1;
      err_o              <= 1'b0;
      addr_hi            <= '0;
      len                <= '0;
      cur_addr           <= '0;
    end else begin
      fr_state           <= fr_next;
      debug_o            <= wr;
      debug_full_reset_o <= full_pulse;
      if (err_set)      err_o <= 1'b1;
      else if (err_clr) err_o <= 1'b0;
      if (cmd_write) begin
        debug_imem_o <= (rx_byte == 8'h01);
        cpu_reset_o  <= 1'b1;
      end else if (run) begin
        cpu_reset_o <= 1'b0;
      end
      if (byte_valid && fr_state == FR_ADDR_HI) addr_hi   <= rx_byte;
      if (byte_valid && fr_state == FR_ADDR_LO) cur_addr  <= AddrWidth'({addr_hi, rx_byte});
      if (byte_valid && fr_state == FR_LEN_HI)  len[15:8] <= rx_byte;
      if (byte_valid && fr_state == FR_LEN_LO)  len[7:0]  <= rx_byte;
      if (wr) begin
        debug_addr_o <= cur_addr;
        debug_data_o <= rx_byte;
        cur_addr     <= cur_addr + AddrWidth'(1);
        len          <= len - 16'd1;
      end
    end
  end

  assign busy_o = (fr_state != FR_SYNC);

endmodule

// File: tb/tb_uart_debug_loader.sv
// Bench for uart_debug_loader: table of load frames plus hand-written corner sequences,
// writes checked through an expected-write queue.
module tb_uart_debug_loader;
  localparam int Cpb = 4;
  localparam int Aw  = 13;
  localparam int Nv  = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          debug_o;
  logic [Aw-1:0] debug_addr_o;
  logic [7:0]    debug_data_o;
  logic          debug_imem_o;
  logic          debug_full_reset_o;
  logic          cpu_reset_o;
  logic          busy_o;
  logic          err_o;

  uart_debug_loader #(.CyclesPerBit(Cpb), .AddrWidth(Aw)) dut (
    .clk                (clk),
    .reset              (reset),
    .rx                 (rx),
    .debug_o            (debug_o),
    .debug_addr_o       (debug_addr_o),
    .debug_data_o       (debug_data_o),
    .debug_imem_o       (debug_imem_o),
    .debug_full_reset_o (debug_full_reset_o),
    .cpu_reset_o        (cpu_reset_o),
    .busy_o             (busy_o),
    .err_o              (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] f;
    int          n;
    int          hdr;
    logic        imem;
    logic [15:0] base;
    int          len;
  } vec_t;

  vec_t       v [Nv];
  logic [21:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          full_pulses = 0;
  logic        full_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every debug_o pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (debug_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", debug_addr_o, debug_data_o);
      end else begin
        check("write", {10'd0, debug_imem_o, debug_addr_o, debug_data_o}, {10'd0, exp_q.pop_front()});
      end
    end
    if (debug_o && debug_full_reset_o) begin
      total++;
      bad++;
      $display("FAIL overlap: debug_o and debug_full_reset_o both 1, expected exclusive");
    end
    if (debug_full_reset_o) begin
      full_pulses++;
      if (full_prev) begin
        total++;
        bad++;
        $display("FAIL clear_width: debug_full_reset_o high 2 cycles, expected 1");
      end
    end
    full_prev = debug_full_reset_o;
  end

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (Cpb) @(negedge clk);
    end
`ifdef UART_DEBUG_LOADER_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (Cpb) @(negedge clk);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_bit;
    repeat (Cpb) @(negedge clk);
    rx = 1'b1;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [95:0] f, input int n);
    for (int i = 0; i < n; i++) send_byte(f[95-8*i -: 8], 1'b1, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  task automatic push_write(input logic imem, input int addr, input logic [7:0] data);
    logic [Aw-1:0] a;
    a = Aw'(addr % (1 << Aw));
    exp_q.push_back({imem, a, data});
  endtask

  initial begin
    logic [95:0] fr;
    logic [7:0]  r0, r1, r2;
    r0 = 8'($urandom_range(0, 255));
    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    v[0] = '{96'hA5_01_0010_0002_DEAD_0000_0000, 8, 0, 1'b1, 16'h0010, 2};
    v[1] = '{96'hA5_02_1FFF_0002_1122_0000_0000, 8, 0, 1'b0, 16'h1FFF, 2};
    v[2] = '{{8'hA5, 8'h01, 16'hFFFE, 16'h0003, r0, r1, r2, 24'h0}, 9, 0, 1'b1, 16'hFFFE, 3};
    v[3] = '{96'hA5_02_0005_0000_0000_0000_0000, 6, 0, 1'b0, 16'h0005, 0};
    v[4] = '{96'h33_A5_02_0123_0001_5A_0000_0000, 8, 1, 1'b0, 16'h0123, 1};

    rx = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_cpu_reset", cpu_reset_o, 1);
    check("rst_debug_o", debug_o, 0);
    check("rst_full_reset", debug_full_reset_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_addr", debug_addr_o, 0);
    check("rst_data", debug_data_o, 0);
    check("rst_imem", debug_imem_o, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < Nv; k++) begin
      fr = v[k].f;
      for (int i = 0; i < v[k].len; i++)
        push_write(v[k].imem, int'(v[k].base) + i, fr[95-8*(v[k].hdr+6+i) -: 8]);
      send_frame(fr, v[k].n);
      check($sformatf("v%0d_drain", k), exp_q.size(), 0);
      check($sformatf("v%0d_busy", k), busy_o, 0);
      check($sformatf("v%0d_err", k), err_o, 0);
      check($sformatf("v%0d_imem", k), debug_imem_o, v[k].imem);
      check($sformatf("v%0d_cpu_reset", k), cpu_reset_o, 1);
    end

    full_pulses = 0;
    send_frame({16'hA503, 80'h0}, 2);
    check("clear_pulses", full_pulses, 1);
    check("clear_busy", busy_o, 0);
    check("clear_cpu_reset", cpu_reset_o, 1);
    send_frame({16'hA504, 80'h0}, 2);
    check("run_cpu_reset", cpu_reset_o, 0);
    check("run_no_clear", full_pulses, 1);

    send_frame({16'hA507, 80'h0}, 2);
    check("badcmd_err", err_o, 1);
    check("badcmd_busy", busy_o, 0);
    send_frame({8'hA5, 88'h0}, 1);
    check("sync_clears_err", err_o, 0);
    check("sync_busy", busy_o, 1);

    // A 2-cycle low glitch while waiting for CMD must not produce a byte.
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (12 * Cpb) @(negedge clk);
    check("glitch_err", err_o, 0);
    check("glitch_busy", busy_o, 1);
    push_write(1'b0, 16'h0020, 8'h77);
    send_frame({48'h02_0020_0001_77, 48'h0}, 6);
    check("glitch_drain", exp_q.size(), 0);
    check("glitch_err_after", err_o, 0);
    check("reload_cpu_reset", cpu_reset_o, 1);

    send_frame({48'hA5_01_0000_0001, 48'h0}, 6);
    send_byte(8'h55, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    check("stop_err", err_o, 1);
    check("stop_busy", busy_o, 0);
    check("stop_drain", exp_q.size(), 0);

    push_write(1'b1, 16'h0040, 8'hD1);
    send_frame({56'hA5_01_0040_0003_D1, 40'h0}, 7);
    check("midrst_first", exp_q.size(), 0);
    check("midrst_busy_before", busy_o, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy_o, 0);
    check("midrst_cpu_reset", cpu_reset_o, 1);
    send_frame({16'hD2D3, 80'h0}, 2);
    check("midrst_busy_after", busy_o, 0);
    check("midrst_err_after", err_o, 0);
    check("midrst_cpu_reset_after", cpu_reset_o, 1);

`ifdef UART_DEBUG_LOADER_PARITY_EN
    send_frame({48'hA5_01_0050_0002, 48'h0}, 6);
    send_byte(8'h3C, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    check("parity_err", err_o, 1);
    check("parity_busy", busy_o, 0);
    check("parity_drain", exp_q.size(), 0);
`endif

    repeat (10) @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
